// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU/load
// pipeline (source 0) and the mult/div unit (source 1), one held write per source.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              sel,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              hold0_valid;
    logic [ADDR_W-1:0] hold0_addr;
    logic [DATA_W-1:0] hold0_data;
    logic              hold1_valid;
    logic [ADDR_W-1:0] hold1_addr;
    logic [DATA_W-1:0] hold1_data;
    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              accept0;
    logic              accept1;

    // Grant from held entries only; on a tie the source that did not win last goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (hold0_valid && hold1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = hold0_valid;
            grant1 = hold1_valid;
        end
    end

    assign req0_ready = !rst && (!hold0_valid || grant0);
    assign req1_ready = !rst && (!hold1_valid || grant1);
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold0_valid  <= 1'b0;
            hold0_addr   <= '0;
            hold0_data   <= '0;
            hold1_valid  <= 1'b0;
            hold1_addr   <= '0;
            hold1_data   <= '0;
            last_grant   <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            sel          <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            // A granted entry drains; an accept on the same edge refills it.
            if (accept0) begin
                hold0_valid <= 1'b1;
                hold0_addr  <= req0_addr;
                hold0_data  <= req0_data;
            end else if (grant0) begin
                hold0_valid <= 1'b0;
            end

            if (accept1) begin
                hold1_valid <= 1'b1;
                hold1_addr  <= req1_addr;
                hold1_data  <= req1_data;
            end else if (grant1) begin
                hold1_valid <= 1'b0;
            end

            // Writes to register 0 are consumed but never strobed.
            if (grant0) begin
                wr_en      <= (hold0_addr != '0);
                wr_addr    <= hold0_addr;
                wr_data    <= hold0_data;
                sel        <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant1) begin
                wr_en      <= (hold1_addr != '0);
                wr_addr    <= hold1_addr;
                wr_data    <= hold1_data;
                sel        <= 1'b1;
                last_grant <= 1'b1;
            end else begin
                wr_en      <= 1'b0;
            end

            if (hold0_valid && hold1_valid && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a pending-write/preference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              iv [2];
    logic [ADDR_W-1:0] ia [2];
    logic [DATA_W-1:0] id [2];
    logic              req0_ready;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sel;
    logic [CNT_W-1:0]  conflict_cnt;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (iv[0]),
        .req0_ready   (req0_ready),
        .req0_addr    (ia[0]),
        .req0_data    (id[0]),
        .req1_valid   (iv[1]),
        .req1_ready   (req1_ready),
        .req1_addr    (ia[1]),
        .req1_data    (id[1]),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sel          (sel),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one pending slot per source, a preferred source for ties, expected outputs.
    logic              pv [2];
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pd [2];
    int                pref;
    int                cnt;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_sel;
    logic              acc [2];
    logic [DATA_W-1:0] rf [32];

    int vectors;
    int miscompares;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pick();
        if (pv[pref]) return pref;
        if (pv[1 - pref]) return 1 - pref;
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            pv[n] = 1'b0;
            pa[n] = '0;
            pd[n] = '0;
        end
        pref   = 0;
        cnt    = 0;
        e_en   = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_sel  = 1'b0;
    endtask

    // One clock: check readies before the edge, advance the model, check outputs after.
    task automatic cycle();
        int   w;
        logic rdy [2];
        @(negedge clk);
        w = pick();
        for (int n = 0; n < 2; n++) begin
            rdy[n] = !rst && (!pv[n] || (w == n));
            acc[n] = iv[n] && rdy[n];
        end
        chk("req0_ready", 32'(req0_ready), 32'(rdy[0]));
        chk("req1_ready", 32'(req1_ready), 32'(rdy[1]));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pv[0] && pv[1]) cnt = (cnt == CNT_MAX) ? cnt : cnt + 1;
            if (w >= 0) begin
                e_en   = (pa[w] != '0);
                e_addr = pa[w];
                e_data = pd[w];
                e_sel  = (w == 1);
                pv[w]  = 1'b0;
                pref   = 1 - w;
            end else begin
                e_en = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    pv[n] = 1'b1;
                    pa[n] = ia[n];
                    pd[n] = id[n];
                end
            end
        end
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_en));
        chk("wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("wr_data", wr_data, e_data);
        chk("sel", 32'(sel), 32'(e_sel));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt));
        if (wr_en === 1'b1) rf[wr_addr] = wr_data;
    endtask

    // Cycle, then advance each source's payload when its write was taken.
    task automatic step();
        cycle();
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                ia[n] = ia[n] + ADDR_W'(1);
                id[n] = id[n] + DATA_W'(1);
            end
        end
    endtask

    task automatic idle(input int n);
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    int wr_count;
    logic [1:0] sel_seq [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        model_reset();
        for (int n = 0; n < 2; n++) begin
            ia[n] = '0;
            id[n] = '0;
            acc[n] = 1'b0;
        end

        // Reset with both valids high: readies low, outputs cleared.
        rst   = 1'b1;
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        cycle();
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        cycle();
        rst = 1'b0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;

        // Single write appears one edge after acceptance.
        iv[0] = 1'b1;
        ia[0] = 5'd5;
        id[0] = 32'hDEADBEEF;
        cycle();
        chk("single_before", 32'(wr_en), 32'h0);
        iv[0] = 1'b0;
        cycle();
        chk("single_en", 32'(wr_en), 32'h1);
        chk("single_addr", 32'(wr_addr), 32'h5);
        chk("single_data", wr_data, 32'hDEADBEEF);
        chk("single_sel", 32'(sel), 32'h0);

        // Four back-to-back source-0 writes.
        iv[0] = 1'b1;
        ia[0] = 5'd10;
        id[0] = 32'h100;
        wr_count = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_en === 1'b1) wr_count++;
        end
        iv[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (wr_en === 1'b1) wr_count++;
        end
        chk("stream_count", 32'(wr_count), 32'd4);

        // Contention from reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        cycle();
        rst   = 1'b0;
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        ia[0] = 5'd1;
        ia[1] = 5'd17;
        id[0] = 32'hA000;
        id[1] = 32'hB000;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            sel_seq[i] = {wr_en, sel};
        end
        chk("cont_g0", 32'(sel_seq[0]), 32'h2);
        chk("cont_g1", 32'(sel_seq[1]), 32'h3);
        chk("cont_g2", 32'(sel_seq[2]), 32'h2);
        chk("cont_g3", 32'(sel_seq[3]), 32'h3);
        chk("cont_cnt", 32'(conflict_cnt), 32'd4);
        idle(3);

        // Write to register 0 is consumed silently; the next one issues.
        iv[1] = 1'b1;
        ia[1] = 5'd0;
        id[1] = 32'h1234;
        cycle();
        iv[1] = 1'b0;
        cycle();
        chk("zero_en", 32'(wr_en), 32'h0);
        iv[1] = 1'b1;
        ia[1] = 5'd7;
        id[1] = 32'h77;
        cycle();
        iv[1] = 1'b0;
        cycle();
        chk("zero_next_en", 32'(wr_en), 32'h1);
        chk("zero_next_addr", 32'(wr_addr), 32'h7);
        chk("zero_next_sel", 32'(sel), 32'h1);
        cycle();

        // Same address from both sources on one edge: source 1 lands last.
        iv[0] = 1'b1;
        ia[0] = 5'd9;
        id[0] = 32'hA;
        iv[1] = 1'b1;
        ia[1] = 5'd9;
        id[1] = 32'hB;
        cycle();
        idle(1);
        chk("same_first", wr_data, 32'hA);
        idle(1);
        chk("same_second", wr_data, 32'hB);
        idle(1);
        chk("same_rf", rf[9], 32'hB);

        // Reset with both holds full discards them.
        iv[0] = 1'b1;
        ia[0] = 5'd3;
        id[0] = 32'h33;
        iv[1] = 1'b1;
        ia[1] = 5'd4;
        id[1] = 32'h44;
        cycle();
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        rst   = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rstmid_ready0", 32'(req0_ready), 32'h1);
        chk("rstmid_ready1", 32'(req1_ready), 32'h1);
        wr_count = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (wr_en === 1'b1) wr_count++;
        end
        chk("rstmid_no_write", 32'(wr_count), 32'd0);

        // Sustained contention saturates the conflict counter.
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        ia[0] = 5'd1;
        ia[1] = 5'd2;
        for (int i = 0; i < (1 << CNT_W) + 4; i++) step();
        chk("sat_cnt", 32'(conflict_cnt), 32'h0000FFFF);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: requester 0 is the ALU/load pipeline and requester 1 is the multi-cycle mult/div unit.
- Buffers one pending write per source and arbitrates round-robin.
- Drives the select of the 32-bit 2:1 writeback mux (sel=0 → source 0, sel=1 → source 1) together with the register-file write enable, address and data.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  source 0 has a write.
- req0_ready  out  1  source 0 write accepted this edge if valid.
- req0_addr  in  ADDR_W  source 0 destination register.
- req0_data  in  DATA_W  source 0 write data.
- req1_valid  in  1  source 1 has a write.
- req1_ready  out  1  source 1 accept.
- req1_addr  in  ADDR_W  source 1 destination register.
- req1_data  in  DATA_W  source 1 write data.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- sel  out  1  writeback mux select; identifies the source of the current write.
- conflict_cnt  out  CNT_W  saturating count of cycles with both holds occupied.

Behaviour:
- Reset (rst=1 at a rising edge):
  - hold0/hold1 empty; wr_en=0, wr_addr=0, wr_data=0, sel=0, conflict_cnt=0.
  - last_grant=1, so source 0 wins the first tie.
  - Reset mid-operation discards held writes without issuing them.
- Holding registers: one entry per source (valid bit, addr, data).
- Ready (combinational, independent of reqN_valid): reqN_ready = !holdN_valid || grantN, where grantN is the grant computed this cycle.
  - Ready is 0 while rst=1.
- Accept: on an edge with reqN_valid && reqN_ready, holdN loads addr/data and holdN_valid=1.
  - If holdN is granted on the same edge, the drain and the refill occur together; holdN stays valid with the new entry.
- Arbitration (combinational, from hold state only; the same-cycle request is never bypassed):
  - Only hold0 valid → grant0.
  - Only hold1 valid → grant1.
  - Both valid → grant the source ≠ last_grant.
  - Neither valid → no grant.
  - last_grant updates to the winner on every grant.
- Output stage (registered) on a grant of source N at edge E:
  - After E: wr_addr=holdN_addr, wr_data=holdN_data, sel=N.
  - wr_en=1 for exactly one cycle, unless holdN_addr==0, in which case wr_en=0. The entry is still consumed and last_grant still updates.
  - With no grant: wr_en=0; wr_addr, wr_data and sel hold their previous values.
- Latency:
  - Accept edge E0 → write visible after E1 when uncontested.
  - Contested: a source waits at most one extra cycle.
- Throughput: at most one write per cycle in total. Each source sustains one write per cycle when the other is idle.
- Same-address writes from both sources are issued in grant order; the later one wins. No merging.
- conflict_cnt increments on each edge where hold0_valid && hold1_valid; it saturates at all-ones and does not wrap.
- No combinational path from the req*_data/req*_addr inputs to the wr_* outputs.

Test Plan:
- Reset: assert rst for 2 cycles with both valids high → req0_ready=req1_ready=0. All outputs 0 after the first reset edge.
- Single source: req0 writes (addr 5, 0xDEADBEEF) at E0 → wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, sel=0 after E1 only. A stream of 4 back-to-back req0 writes → 4 consecutive wr_en cycles.
- Contention, both sources valid every cycle:
  - First grants go 0,1,0,1.
  - sel alternates 0,1,0,1.
  - Each source's ready is asserted every other cycle once its hold is full.
  - conflict_cnt increments once per cycle.
- $zero: req1 writes addr 0, data 0x1234 → wr_en stays 0, req1_ready returns to 1 next cycle, and the next req1 write (addr 7) issues normally.
- Same address: req0 (addr 9, 0xA) and req1 (addr 9, 0xB) accepted on the same edge → writes issue as 0xA then 0xB, the register ends at 0xB.
- Reset mid-operation and saturation:
  - Assert rst with both holds full → no wr_en follows; both readys are 1 on the first cycle after rst deasserts.
  - Force contention for 2^CNT_W + 3 cycles → conflict_cnt holds at 0xFFFF.
